// File: rtl/simon_cbc_engine.sv
// Iterative Simon block cipher, one round per clock, with a cached round-key
// schedule and ECB/CBC chaining in both directions.
module simon_cbc_engine #(
  parameter int WW  = 32,
  parameter int NKW = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              active_o,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  input  logic              key_new_i,
  input  logic              iv_ld_i,
  input  logic [2*WW-1:0]   iv_i,
  input  logic [2*WW-1:0]   pt_i,
  input  logic [NKW*WW-1:0] key_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [1:0]        mode_o,
  output logic [2*WW-1:0]   ct_o
);

  // z sequences written MSB-first as published: element i is bit 61-i
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  function automatic int calc_t(input int ww, input int m);
    case (ww)
      16:      return 32;
      24:      return 36;
      32:      return (m == 3) ? 42 : 44;
      48:      return (m == 2) ? 52 : 54;
      default: return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
    endcase
  endfunction

  function automatic logic [61:0] calc_z(input int ww, input int m);
    if (ww == 16 || (ww == 24 && m == 3)) return Z0;
    if (ww == 24) return Z1;
    if (m == 2 || (ww == 32 && m == 3)) return Z2;
    if (m == 3 || ww == 32) return Z3;
    return Z4;
  endfunction

  localparam int          T    = calc_t(WW, NKW);
  localparam logic [61:0] ZSEQ = calc_z(WW, NKW);
  localparam int          CW   = $clog2(T);
  localparam int          RKN  = 1 << CW;

  localparam logic [CW-1:0] T_LAST = CW'(T - 1);
  localparam logic [CW-1:0] K_LAST = CW'(T - NKW - 1);
  localparam logic [CW-1:0] K_M    = CW'(NKW);
  localparam logic [CW-1:0] K_M1   = CW'(NKW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEXP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [WW-1:0] rol(input logic [WW-1:0] v, input int s);
    return (v << s) | (v >> (WW - s));
  endfunction

  function automatic logic [WW-1:0] ror(input logic [WW-1:0] v, input int s);
    return (v >> s) | (v << (WW - s));
  endfunction

  function automatic logic [WW-1:0] f_rnd(input logic [WW-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   x_q, x_d, y_q, y_d;
  logic [2*WW-1:0] blk_q, blk_d, chain_q, chain_d, ct_q, ct_d;
  logic [1:0]      mode_q, mode_d, mode_o_q, mode_o_d;
  logic            cache_q, cache_d;
  logic [WW-1:0]   rk_q [RKN];
  logic [WW-1:0]   rk_d [RKN];

  logic [CW-1:0]   kidx;
  logic [WW-1:0]   x_r, k_tmp, k_new;
  logic [7:0]      kc8;
  logic [5:0]      zi;
  logic [2*WW-1:0] chain_in, st_in, res;

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign active_o = (state_q != S_IDLE);
  assign ct_o     = ct_q;
  assign mode_o   = mode_o_q;

  // Decryption runs the encrypt datapath on swapped words with reversed keys
  assign kidx = mode_q[0] ? (T_LAST - cnt_q) : cnt_q;
  assign x_r  = y_q ^ f_rnd(x_q) ^ rk_q[kidx];

  assign chain_in = iv_ld_i ? iv_i : chain_q;
  assign st_in    = (mode_i == 2'b10) ? (pt_i ^ chain_in) : pt_i;

  always_comb begin
    res = mode_q[0] ? {x_q, x_r} : {x_r, x_q};
    if (mode_q == 2'b11) res = res ^ chain_q;
  end

  always_comb begin
    k_tmp = ror(rk_q[cnt_q + K_M1], 3);
    if (NKW == 4) k_tmp = k_tmp ^ rk_q[cnt_q + CW'(1)];
    k_tmp = k_tmp ^ ror(k_tmp, 1);
    kc8   = 8'(cnt_q);
    zi    = (kc8 >= 8'd62) ? 6'(kc8 - 8'd62) : 6'(kc8);
    k_new = ~rk_q[cnt_q] ^ k_tmp ^ WW'(ZSEQ[6'd61 - zi]) ^ WW'(3);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    blk_d    = blk_q;
    chain_d  = chain_q;
    mode_d   = mode_q;
    mode_o_d = mode_o_q;
    ct_d     = ct_q;
    cache_d  = cache_q;
    rk_d     = rk_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          mode_d = mode_i;
          blk_d  = pt_i;
          cnt_d  = '0;
          if (iv_ld_i) chain_d = iv_i;
          if (mode_i[0]) {x_d, y_d} = {st_in[WW-1:0], st_in[2*WW-1:WW]};
          else           {x_d, y_d} = st_in;
          if (key_new_i || !cache_q) begin
            for (int i = 0; i < NKW; i++) rk_d[CW'(i)] = key_i[i*WW +: WW];
            cache_d = 1'b0;
            state_d = S_KEXP;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_KEXP: begin
        rk_d[cnt_q + K_M] = k_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == K_LAST) begin
          cnt_d   = '0;
          cache_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d   = x_r;
        y_d   = x_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == T_LAST) begin
          ct_d     = res;
          mode_o_d = mode_q;
          if (mode_q == 2'b10) chain_d = res;
          if (mode_q == 2'b11) chain_d = blk_q;
          state_d  = S_DONE;
        end
      end
      default: begin
        if (ready_i) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      blk_q    <= '0;
      chain_q  <= '0;
      mode_q   <= '0;
      mode_o_q <= '0;
      ct_q     <= '0;
      cache_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      blk_q    <= blk_d;
      chain_q  <= chain_d;
      mode_q   <= mode_d;
      mode_o_q <= mode_o_d;
      ct_q     <= ct_d;
      cache_q  <= cache_d;
    end
  end

  // Round-key storage carries no reset; cache_q alone says whether it is usable
  always_ff @(posedge clk) begin
    rk_q <= rk_d;
  end

endmodule

// File: tb/tb_simon_cbc_engine.sv
// Scoreboard bench for simon_cbc_engine: 64/128 instance for ECB/CBC, timing,
// back-pressure and reset, plus a 32/64 instance for the small configuration.
module tb_simon_cbc_engine;

  localparam logic [127:0] KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  P1  = 64'h656b696c_20646e75;
  localparam logic [63:0]  C1  = 64'h44c8fc20_b9dfa07a;
  localparam logic [63:0]  P2  = 64'h01234567_89abcdef;
  localparam logic [63:0]  P3  = 64'hfedcba98_76543210;
  localparam logic [63:0]  IVX = 64'h0f1e2d3c_4b5a6978;
  localparam logic [63:0]  K16 = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  P16 = 32'h6565_6877;
  localparam logic [31:0]  C16 = 32'hc69b_e9bb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst_n;
  logic         valid_i, ready_o, active_o, key_new_i, iv_ld_i, valid_o, ready_i;
  logic [1:0]   mode_i, mode_o;
  logic [63:0]  iv_i, pt_i, ct_o;
  logic [127:0] key_i;

  logic         s_valid_i, s_ready_o, s_active_o, s_key_new_i, s_iv_ld_i, s_valid_o, s_ready_i;
  logic [1:0]   s_mode_i, s_mode_o;
  logic [31:0]  s_iv_i, s_pt_i, s_ct_o;
  logic [63:0]  s_key_i;

  simon_cbc_engine #(.WW(32), .NKW(4)) dut (
    .clk(clk), .arst_n(arst_n), .active_o(active_o), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .key_new_i(key_new_i), .iv_ld_i(iv_ld_i), .iv_i(iv_i), .pt_i(pt_i),
    .key_i(key_i), .valid_o(valid_o), .ready_i(ready_i), .mode_o(mode_o), .ct_o(ct_o)
  );

  simon_cbc_engine #(.WW(16), .NKW(4)) dut16 (
    .clk(clk), .arst_n(arst_n), .active_o(s_active_o), .valid_i(s_valid_i), .ready_o(s_ready_o),
    .mode_i(s_mode_i), .key_new_i(s_key_new_i), .iv_ld_i(s_iv_ld_i), .iv_i(s_iv_i), .pt_i(s_pt_i),
    .key_i(s_key_i), .valid_o(s_valid_o), .ready_i(s_ready_i), .mode_o(s_mode_o), .ct_o(s_ct_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  mode;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  logic seen32 = 1'b0;
  logic seen16 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Independent Simon64/128 reference
  function automatic logic [31:0] rr(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction
  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction
  function automatic logic [44*32-1:0] ref_ks(input logic [127:0] key);
    logic [31:0] k [44];
    logic [31:0] t;
    logic [44*32-1:0] out;
    string z3 = "11011011101011000110010111100000010010001010011100110100001111";
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = rr(k[i-1], 3) ^ k[i-3];
      t = t ^ rr(t, 1);
      k[i] = ~k[i-4] ^ t ^ ((z3[i-4] == "1") ? 32'd1 : 32'd0) ^ 32'd3;
    end
    for (int i = 0; i < 44; i++) out[32*i +: 32] = k[i];
    return out;
  endfunction
  function automatic logic [63:0] ref_enc(input logic [63:0] pt);
    logic [44*32-1:0] ks = ref_ks(KEY);
    logic [31:0] x = pt[63:32];
    logic [31:0] y = pt[31:0];
    logic [31:0] t;
    for (int r = 0; r < 44; r++) begin
      t = x;
      x = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ ks[32*r +: 32];
      y = t;
    end
    return {x, y};
  endfunction

  always @(negedge clk) begin
    if (valid_o && !seen32) begin
      if (q32.size() == 0) begin
        n_chk++;
        $display("FAIL out32_unexpected: got ct %h with no request pending", ct_o);
      end else begin
        e32 = q32.pop_front();
        check("ct32", ct_o, e32.data);
        check("mode32", 64'(mode_o), 64'(e32.mode));
        if (e32.lat > 0) check("lat32", 64'(cyc - e32.acc), 64'(e32.lat));
      end
      seen32 = 1'b1;
    end
    if (valid_o && ready_i) seen32 = 1'b0;
  end

  always @(negedge clk) begin
    if (s_valid_o && !seen16) begin
      if (q16.size() == 0) begin
        n_chk++;
        $display("FAIL out16_unexpected: got ct %h with no request pending", s_ct_o);
      end else begin
        e16 = q16.pop_front();
        check("ct16", 64'(s_ct_o), e16.data);
        check("mode16", 64'(s_mode_o), 64'(e16.mode));
        if (e16.lat > 0) check("lat16", 64'(cyc - e16.acc), 64'(e16.lat));
      end
      seen16 = 1'b1;
    end
    if (s_valid_o && s_ready_i) seen16 = 1'b0;
  end

  task automatic wait_ready32();
    int n = 0;
    while (!ready_o && n < 1000) begin @(posedge clk); #1; n++; end
    if (!ready_o) check("ready32_timeout", 64'(ready_o), 64'd1);
  endtask

  task automatic send32(input logic [1:0] m, input logic kn, input logic ivl, input logic [63:0] iv,
                        input logic [63:0] blk, input logic [63:0] expv, input int lat, input logic push);
    wait_ready32();
    mode_i = m; key_new_i = kn; iv_ld_i = ivl; iv_i = iv; pt_i = blk; valid_i = 1'b1;
    if (push) q32.push_back('{data: expv, mode: m, acc: cyc, lat: lat});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send16(input logic [1:0] m, input logic kn, input logic [31:0] blk,
                        input logic [31:0] expv, input int lat);
    int n = 0;
    while (!s_ready_o && n < 1000) begin @(posedge clk); #1; n++; end
    if (!s_ready_o) check("ready16_timeout", 64'(s_ready_o), 64'd1);
    s_mode_i = m; s_key_new_i = kn; s_iv_ld_i = 1'b0; s_pt_i = blk; s_valid_i = 1'b1;
    q16.push_back('{data: 64'(expv), mode: m, acc: cyc, lat: lat});
    @(posedge clk); #1;
    s_valid_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    logic [63:0] c2, c3, x1, x2, x3, ebp;
    int n;
    arst_n = 1'b0;
    valid_i = 1'b0; mode_i = '0; key_new_i = 1'b0; iv_ld_i = 1'b0; iv_i = '0; pt_i = '0;
    key_i = KEY; ready_i = 1'b1;
    s_valid_i = 1'b0; s_mode_i = '0; s_key_new_i = 1'b0; s_iv_ld_i = 1'b0; s_iv_i = '0;
    s_pt_i = '0; s_key_i = K16; s_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_active", 64'(active_o), 64'd0);
    check("rst_ct", ct_o, 64'd0);
    check("rst_mode", 64'(mode_o), 64'd0);
    arst_n = 1'b1;

    // ECB with expansion, then cached decrypt
    send32(2'b00, 1'b1, 1'b0, '0, P1, C1, 85, 1'b1);
    check("active_busy", 64'(active_o), 64'd1);
    check("ready_busy", 64'(ready_o), 64'd0);
    send32(2'b01, 1'b0, 1'b0, '0, C1, P1, 45, 1'b1);

    // CBC with zero IV: first block equals the ECB result
    c2 = ref_enc(P2 ^ C1);
    c3 = ref_enc(P3 ^ c2);
    send32(2'b10, 1'b0, 1'b1, 64'd0, P1, C1, 45, 1'b1);
    send32(2'b10, 1'b0, 1'b0, 64'd0, P2, c2, 45, 1'b1);
    send32(2'b10, 1'b0, 1'b0, 64'd0, P3, c3, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b1, 64'd0, C1, P1, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b0, 64'd0, c2, P2, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b0, 64'd0, c3, P3, 45, 1'b1);

    // CBC with non-zero IV
    x1 = ref_enc(P1 ^ IVX);
    x2 = ref_enc(P2 ^ x1);
    x3 = ref_enc(P3 ^ x2);
    send32(2'b10, 1'b0, 1'b1, IVX, P1, x1, 45, 1'b1);
    send32(2'b10, 1'b0, 1'b0, IVX, P2, x2, 45, 1'b1);
    send32(2'b10, 1'b0, 1'b0, IVX, P3, x3, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b1, IVX, x1, P1, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b0, IVX, x2, P2, 45, 1'b1);
    send32(2'b11, 1'b0, 1'b0, IVX, x3, P3, 45, 1'b1);

    // Back-pressure: DONE held, stray requests ignored
    wait_ready32();
    ready_i = 1'b0;
    ebp = ref_enc(P2);
    send32(2'b00, 1'b0, 1'b0, '0, P2, ebp, 45, 1'b1);
    n = 0;
    while (!valid_o && n < 200) begin @(posedge clk); #1; n++; end
    check("bp_valid", 64'(valid_o), 64'd1);
    for (int i = 0; i < 20; i++) begin
      check("bp_ct", ct_o, ebp);
      check("bp_ctl", 64'({valid_o, ready_o, mode_o}), 64'h8);
      valid_i = (i % 3 == 0); key_new_i = 1'b1; mode_i = 2'b11; pt_i = ~P2;
      @(posedge clk); #1;
    end
    valid_i = 1'b0; key_new_i = 1'b0;
    ready_i = 1'b1;

    // Reset during RUN drops the block, chain and cache
    send32(2'b00, 1'b0, 1'b0, '0, P3, '0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("run_active", 64'(active_o), 64'd1);
    arst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_ct", ct_o, 64'd0);
    arst_n = 1'b1;
    send32(2'b10, 1'b0, 1'b0, '0, P1, C1, 85, 1'b1);

    // Simon32/64
    send16(2'b00, 1'b1, P16, C16, 61);
    send16(2'b01, 1'b0, C16, P16, 33);

    n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || valid_o || s_valid_o) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 64'(q32.size() + q16.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
